// File: rtl/mram_wb_spi.sv
// Wishbone-style 32-bit word slave backed by an SPI MRAM (READ 0x03 / WRITE 0x02 / WREN 0x06).
// Define MRAM_BURSTWRITE_EN to turn full-word writes into a single 4-byte WRITE frame.
module mram_wb_spi #(
    parameter int unsigned SPISPED = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic [29:0] adr_i,
    output logic        ack_o,
    output logic        spiCs_o,
    output logic        spiClk_o,
    output logic        spiMosi_o,
    input  logic        spiMiso_i
);
`ifdef MRAM_BURSTWRITE_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif
    localparam logic [15:0] CNT_LAST = 16'(SPISPED - 1);

    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP, ACK} state_t;
    typedef enum logic [1:0] {K_NONE, K_READ, K_WREN, K_WRITE} kind_t;

    state_t      state_q;
    kind_t       kind_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] wdat_q;
    logic [21:0] adr_q;
    logic [1:0]  lane_q;
    logic [62:0] tx_q;
    logic [6:0]  bit_q;
    logic [6:0]  len_q;
    logic [31:0] rx_q;
    logic [15:0] cnt_q;
    logic        cs_q;
    logic        sck_q;
    logic        mosi_q;
    logic        ack_q;
    logic [31:0] dat_q;

    logic        unused_adr;
    logic        burst;
    logic        cnt_done;
    logic [2:0]  first_lane_w;
    logic [2:0]  after_lane_w;
    logic        nxt_done_d;
    kind_t       nxt_kind_d;
    logic [1:0]  nxt_lane_d;
    logic [63:0] nxt_tx_d;
    logic [6:0]  nxt_len_d;

    assign unused_adr = ^adr_i[29:22];
    assign burst      = BURST_EN && (sel_q == 4'hF);
    assign cnt_done   = (cnt_q == CNT_LAST);

    // Lowest selected lane at or above 'from'; 4 means none left.
    function automatic logic [2:0] first_lane(input logic [3:0] sel, input logic [2:0] from);
        logic [2:0] res;
        if      (sel[0] && from <= 3'd0) res = 3'd0;
        else if (sel[1] && from <= 3'd1) res = 3'd1;
        else if (sel[2] && from <= 3'd2) res = 3'd2;
        else if (sel[3] && from <= 3'd3) res = 3'd3;
        else                             res = 3'd4;
        return res;
    endfunction

    // Frame that follows the one just finished (K_NONE: none sent yet for this request).
    always_comb begin
        first_lane_w = first_lane(sel_q, 3'd0);
        after_lane_w = first_lane(sel_q, {1'b0, lane_q} + 3'd1);
        nxt_done_d   = 1'b0;
        nxt_kind_d   = K_WREN;
        nxt_lane_d   = lane_q;
        nxt_tx_d     = {8'h06, 56'h0};
        nxt_len_d    = 7'd8;
        case (kind_q)
            K_NONE: begin
                if (!we_q) begin
                    nxt_kind_d = K_READ;
                    nxt_tx_d   = {8'h03, adr_q, 2'b00, 32'h0};
                    nxt_len_d  = 7'd64;
                end else begin
                    nxt_lane_d = first_lane_w[1:0];
                end
            end
            K_WREN: begin
                nxt_kind_d = K_WRITE;
                if (burst) begin
                    nxt_tx_d  = {8'h02, adr_q, 2'b00, wdat_q[7:0], wdat_q[15:8],
                                 wdat_q[23:16], wdat_q[31:24]};
                    nxt_len_d = 7'd64;
                end else begin
                    nxt_tx_d  = {8'h02, adr_q, lane_q, wdat_q[{lane_q, 3'b000} +: 8], 24'h0};
                    nxt_len_d = 7'd40;
                end
            end
            K_WRITE: begin
                if (burst || after_lane_w[2]) nxt_done_d = 1'b1;
                else                          nxt_lane_d = after_lane_w[1:0];
            end
            default: nxt_done_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            kind_q  <= K_NONE;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            adr_q   <= '0;
            lane_q  <= '0;
            tx_q    <= '0;
            bit_q   <= '0;
            len_q   <= '0;
            rx_q    <= '0;
            cnt_q   <= '0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (stb_i) begin
                        we_q   <= we_i;
                        sel_q  <= sel_i;
                        wdat_q <= dat_i;
                        adr_q  <= adr_i[21:0];
                        kind_q <= K_NONE;
                        if (we_i && sel_i == 4'h0) begin
                            state_q <= ACK;
                            ack_q   <= 1'b1;
                        end else begin
                            // Enter GAP already expired so the first frame starts next cycle.
                            state_q <= GAP;
                            cnt_q   <= CNT_LAST;
                        end
                    end
                end
                CS_SETUP: begin
                    if (cnt_done) begin
                        cnt_q   <= '0;
                        sck_q   <= 1'b1;
                        rx_q    <= {rx_q[30:0], spiMiso_i};
                        state_q <= SHIFT;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                SHIFT: begin
                    if (cnt_done) begin
                        cnt_q <= '0;
                        if (sck_q) begin
                            sck_q <= 1'b0;
                            if (bit_q == len_q - 7'd1) begin
                                mosi_q  <= 1'b0;
                                state_q <= CS_HOLD;
                            end else begin
                                mosi_q <= tx_q[62];
                                tx_q   <= {tx_q[61:0], 1'b0};
                                bit_q  <= bit_q + 7'd1;
                            end
                        end else begin
                            sck_q <= 1'b1;
                            rx_q  <= {rx_q[30:0], spiMiso_i};
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                CS_HOLD: begin
                    if (cnt_done) begin
                        cnt_q   <= '0;
                        cs_q    <= 1'b1;
                        state_q <= GAP;
                        if (kind_q == K_READ)
                            dat_q <= {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                GAP: begin
                    if (cnt_done) begin
                        cnt_q <= '0;
                        if (nxt_done_d) begin
                            state_q <= ACK;
                            ack_q   <= 1'b1;
                        end else begin
                            kind_q  <= nxt_kind_d;
                            lane_q  <= nxt_lane_d;
                            mosi_q  <= nxt_tx_d[63];
                            tx_q    <= nxt_tx_d[62:0];
                            len_q   <= nxt_len_d;
                            bit_q   <= '0;
                            cs_q    <= 1'b0;
                            state_q <= CS_SETUP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ACK:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dat_o     = dat_q;
    assign ack_o     = ack_q;
    assign spiCs_o   = cs_q;
    assign spiClk_o  = sck_q;
    assign spiMosi_o = mosi_q;

endmodule

// File: tb/tb_mram_wb_spi.sv
// Directed scoreboard bench for mram_wb_spi with an SPI MRAM bus monitor and MISO model.
`timescale 1ns/1ps
module tb_mram_wb_spi;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stb_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic [29:0] adr_i;
    logic        ack_o;
    logic        spiCs_o;
    logic        spiClk_o;
    logic        spiMosi_o;
    logic        spiMiso_i;

    typedef struct packed {
        logic [31:0] len;
        logic [63:0] bits;
    } frame_t;

    frame_t      exp_q[$];
    frame_t      got_q[$];
    logic [31:0] rdq[$];

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    int unsigned nb = 0;
    logic [63:0] cap = '0;
    logic        cs_prev, sck_prev;
    time         last_rise = 0;
    time         last_period = 0;
    int unsigned period_bad = 0;
    int unsigned idle_tog = 0;
    logic [63:0] miso_pat = '0;

    mram_wb_spi #(.SPISPED(1)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .stb_i     (stb_i),
        .we_i      (we_i),
        .sel_i     (sel_i),
        .dat_i     (dat_i),
        .dat_o     (dat_o),
        .adr_i     (adr_i),
        .ack_o     (ack_o),
        .spiCs_o   (spiCs_o),
        .spiClk_o  (spiClk_o),
        .spiMosi_o (spiMosi_o),
        .spiMiso_i (spiMiso_i)
    );

    initial forever #5 clk_i = ~clk_i;

    // MRAM model output: bit presented is the next one after the rising edges seen so far.
    assign spiMiso_i = (nb < 64) ? miso_pat[~nb[5:0]] : 1'b0;

    // SPI monitor: captures MOSI on SCK rise, records each frame when CS rises.
    initial begin
        forever begin
            @(spiCs_o or spiClk_o);
            if (rst_i === 1'b1) begin
                if (spiCs_o === 1'b1 && cs_prev === 1'b0) begin
                    got_q.push_back({nb, cap});
                end else if (spiCs_o === 1'b0 && cs_prev === 1'b1) begin
                    nb  = 0;
                    cap = '0;
                end else if (spiCs_o === 1'b1 && spiClk_o !== sck_prev) begin
                    idle_tog++;
                end else if (spiClk_o === 1'b1 && sck_prev === 1'b0) begin
                    if (nb != 0) begin
                        last_period = $time - last_rise;
                        if (last_period != 20) period_bad++;
                    end
                    last_rise = $time;
                    cap = {cap[62:0], spiMosi_o};
                    nb++;
                end
            end
            cs_prev  = spiCs_o;
            sck_prev = spiClk_o;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input int unsigned len, input logic [63:0] bits);
        exp_q.push_back({len, bits});
    endtask

    task automatic check_frames(input string tag);
        frame_t g, e;
        while (got_q.size() != 0) begin
            g = got_q.pop_front();
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else                   e = '1;
            chk({tag, "_frame"}, g, e);
        end
        chk({tag, "_frames_left"}, exp_q.size(), 0);
    endtask

    task automatic bus(input logic w, input logic [3:0] s, input logic [31:0] d,
                       input logic [29:0] a, input bit drop,
                       output int unsigned cyc, output logic [31:0] rd);
        logic acked;
        @(negedge clk_i);
        stb_i = 1'b1; we_i = w; sel_i = s; dat_i = d; adr_i = a;
        @(posedge clk_i); #1;
        we_i = ~w; sel_i = ~s; dat_i = ~d; adr_i = ~a;
        cyc   = 1;
        acked = 1'b0;
        while (!acked && cyc < 4000) begin
            if (ack_o === 1'b1) begin
                acked = 1'b1;
            end else begin
                if (drop && cyc == 20) stb_i = 1'b0;
                @(posedge clk_i); #1;
                cyc++;
            end
        end
        rd    = dat_o;
        stb_i = 1'b0;
        chk("ack_seen", acked, 1'b1);
        if (acked) begin
            @(posedge clk_i); #1;
            chk("ack_one_cycle", ack_o, 1'b0);
        end
    endtask

    task automatic do_read(input logic [29:0] a, input logic [23:0] baddr, input logic [31:0] resp,
                           input logic [31:0] exp_dat, input bit drop, input string tag);
        int unsigned cyc;
        logic [31:0] rd, e;
        miso_pat = {32'h0, resp};
        push_frame(64, {8'h03, baddr, 32'h0});
        rdq.push_back(exp_dat);
        bus(1'b0, 4'h0, 32'h0, a, drop, cyc, rd);
        e = rdq.pop_front();
        chk({tag, "_data"}, rd, e);
        chk({tag, "_latency_le_136"}, cyc <= 136, 1'b1);
        check_frames(tag);
    endtask

    initial begin
        int unsigned cyc;
        int unsigned acks;
        logic [31:0] rd;

        rst_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; sel_i = '0; dat_i = '0; adr_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_cs", spiCs_o, 1'b1);
        chk("rst_sck", spiClk_o, 1'b0);
        chk("rst_mosi", spiMosi_o, 1'b0);
        chk("rst_ack", ack_o, 1'b0);
        chk("rst_dat", dat_o, 32'h0);
        rst_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        chk("idle_no_sck", idle_tog, 0);

        // Basic read: bytes 11,22,33,44 arrive in order.
        do_read(30'h0000_0004, 24'h000010, 32'h1122_3344, 32'h4433_2211, 1'b0, "read1");
        chk("sck_period", last_period, 20);
        chk("sck_period_all", period_bad, 0);

        // Two-lane write.
        push_frame(8, 64'h06);
        push_frame(40, 64'h02_000004_DD);
        push_frame(8, 64'h06);
        push_frame(40, 64'h02_000006_BB);
        bus(1'b1, 4'b0101, 32'hAABB_CCDD, 30'h1, 1'b0, cyc, rd);
        check_frames("wr0101");
        chk("dat_hold_after_write", dat_o, 32'h4433_2211);

        // Empty write: immediate ack, no SPI frames.
        bus(1'b1, 4'b0000, 32'hDEAD_BEEF, 30'h7, 1'b0, cyc, rd);
        chk("wr_sel0_latency", cyc, 1);
        chk("wr_sel0_no_frame", got_q.size(), 0);

        // Read with stb dropped mid-frame and high address bits set.
        do_read(30'h3FC0_0005, 24'h000014, 32'hA1B2_C3D4, 32'hD4C3_B2A1, 1'b1, "read_drop");

        // Read aborted by reset mid-frame.
        miso_pat = {32'h0, 32'hFFFF_FFFF};
        @(negedge clk_i);
        stb_i = 1'b1; we_i = 1'b0; sel_i = '0; adr_i = 30'h8;
        @(posedge clk_i); #1;
        stb_i = 1'b0;
        repeat (30) @(posedge clk_i);
        #1;
        chk("abort_cs_low_before", spiCs_o, 1'b0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        chk("abort_cs_high", spiCs_o, 1'b1);
        chk("abort_sck_low", spiClk_o, 1'b0);
        chk("abort_ack_low", ack_o, 1'b0);
        chk("abort_dat_cleared", dat_o, 32'h0);
        rst_i = 1'b1;
        acks = 0;
        repeat (10) begin
            @(posedge clk_i); #1;
            if (ack_o === 1'b1) acks++;
        end
        chk("abort_no_ack", acks, 0);
        check_frames("abort");

        do_read(30'h3FFF_FFFF, 24'hFFFFFC, 32'h5A5A_F00F, 32'h0FF0_5A5A, 1'b0, "read_after_abort");

        // Full-word write.
        push_frame(8, 64'h06);
`ifdef MRAM_BURSTWRITE_EN
        push_frame(64, 64'h02000000_04030201);
`else
        push_frame(40, 64'h02_000000_04);
        push_frame(8, 64'h06);
        push_frame(40, 64'h02_000001_03);
        push_frame(8, 64'h06);
        push_frame(40, 64'h02_000002_02);
        push_frame(8, 64'h06);
        push_frame(40, 64'h02_000003_01);
`endif
        bus(1'b1, 4'hF, 32'h0102_0304, 30'h0, 1'b0, cyc, rd);
        check_frames("wr_full");

        // Top lane only.
        push_frame(8, 64'h06);
        push_frame(40, 64'h02_00000B_12);
        bus(1'b1, 4'b1000, 32'h1234_5678, 30'h2, 1'b0, cyc, rd);
        check_frames("wr1000");

        repeat (5) @(posedge clk_i);
        #1;
        chk("end_no_idle_sck", idle_tog, 0);
        chk("end_period_all", period_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
